// File: rtl/seg7_disp_sched.sv
// Six-digit seven-segment display scheduler: arbitrates two requesters against a default value with a minimum dwell.
// Optional blink support is compiled in with `define SEG7_BLINK_EN.
module seg7_disp_sched #(
  parameter int unsigned DWELL     = 50000000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [23:0] iDEFAULT,
  input  logic        iREQ0,
  input  logic [23:0] iDATA0,
  input  logic        iREQ1,
  input  logic [23:0] iDATA1,
  input  logic [5:0]  iBLINK_MASK,
  output logic [23:0] oDIG,
  output logic [5:0]  oBLANK,
  output logic        oACK0,
  output logic        oACK1,
  output logic [1:0]  oOWNER
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHOW0 = 2'b01,
    SHOW1 = 2'b10
  } stateT;

  stateT         state, nxtState;
  logic [CW-1:0] dwellCnt, nxtCnt;
  logic [23:0]   dig, nxtDig;
  logic          ack0, nxtAck0;
  logic          ack1, nxtAck1;
  logic          take0, take1;

  // State register plus registered outputs
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      dwellCnt <= '0;
      dig      <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
    end else begin
      state    <= nxtState;
      dwellCnt <= nxtCnt;
      dig      <= nxtDig;
      ack0     <= nxtAck0;
      ack1     <= nxtAck1;
    end
  end

  // Arbitration: requester 0 wins from IDLE, the other requester wins on dwell expiry
  always_comb begin
    nxtState = state;
    take0    = 1'b0;
    take1    = 1'b0;
    case (state)
      IDLE: begin
        if (iREQ0)      take0 = 1'b1;
        else if (iREQ1) take1 = 1'b1;
      end
      SHOW0: begin
        if (dwellCnt == '0) begin
          if (iREQ1)      take1 = 1'b1;
          else if (iREQ0) take0 = 1'b1;
          else            nxtState = IDLE;
        end
      end
      SHOW1: begin
        if (dwellCnt == '0) begin
          if (iREQ0)      take0 = 1'b1;
          else if (iREQ1) take1 = 1'b1;
          else            nxtState = IDLE;
        end
      end
      default: nxtState = IDLE;
    endcase
    if (take0) nxtState = SHOW0;
    if (take1) nxtState = SHOW1;
  end

  // Next register values for display data, acks and dwell counter
  always_comb begin
    nxtDig  = dig;
    nxtAck0 = 1'b0;
    nxtAck1 = 1'b0;
    nxtCnt  = (dwellCnt != '0) ? dwellCnt - CW'(1) : '0;
    if (take0) begin
      nxtDig  = iDATA0;
      nxtAck0 = 1'b1;
      nxtCnt  = CW'(DWELL - 1);
    end else if (take1) begin
      nxtDig  = iDATA1;
      nxtAck1 = 1'b1;
      nxtCnt  = CW'(DWELL - 1);
    end else if (nxtState == IDLE) begin
      nxtDig  = iDEFAULT;
      nxtCnt  = '0;
    end
  end

  assign oDIG   = dig;
  assign oACK0  = ack0;
  assign oACK1  = ack1;
  assign oOWNER = state;

`ifdef SEG7_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blinkCnt;
  logic          blinkPhase;
  logic [5:0]    blank;

  // Free-running blink divider; phase flips once per BLINK_DIV cycles
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
      blank      <= '0;
    end else begin
      if (blinkCnt == BW'(BLINK_DIV - 1)) begin
        blinkCnt   <= '0;
        blinkPhase <= ~blinkPhase;
      end else begin
        blinkCnt <= blinkCnt + BW'(1);
      end
      blank <= blinkPhase ? iBLINK_MASK : 6'b000000;
    end
  end

  assign oBLANK = blank;
`else
  logic unusedBlink;
  assign unusedBlink = ^{iBLINK_MASK, BLINK_DIV};
  assign oBLANK      = 6'b000000;
`endif

endmodule

// File: tb/tb_seg7_disp_sched.sv
// Directed self-checking bench for seg7_disp_sched (DWELL=4 and DWELL=1 instances, BLINK_DIV=3).
module tb_seg7_disp_sched;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [23:0] dflt, data0, data1;
  logic        req0, req1, req1b;
  logic [5:0]  mask;
  logic [23:0] dig, dig1;
  logic [5:0]  blank, blank1;
  logic        ack0, ack1, ack0b, ack1b;
  logic [1:0]  owner, owner1;

  int total = 0;
  int bad   = 0;

  always #5 iCLK = ~iCLK;

  seg7_disp_sched #(.DWELL(4), .BLINK_DIV(3)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iDEFAULT(dflt),
    .iREQ0(req0), .iDATA0(data0), .iREQ1(req1), .iDATA1(data1),
    .iBLINK_MASK(mask), .oDIG(dig), .oBLANK(blank),
    .oACK0(ack0), .oACK1(ack1), .oOWNER(owner)
  );

  seg7_disp_sched #(.DWELL(1), .BLINK_DIV(3)) dut1 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iDEFAULT(dflt),
    .iREQ0(1'b0), .iDATA0(data0), .iREQ1(req1b), .iDATA1(data1),
    .iBLINK_MASK(mask), .oDIG(dig1), .oBLANK(blank1),
    .oACK0(ack0b), .oACK1(ack1b), .oOWNER(owner1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    iRST_N = 1'b0;
    dflt   = 24'h123456;
    data0  = 24'h0;
    data1  = 24'h0;
    req0   = 1'b0;
    req1   = 1'b0;
    req1b  = 1'b0;
    mask   = 6'b000011;

    repeat (2) @(negedge iCLK);
    chk("rst_dig", 32'(dig), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_acks", 32'({ack0, ack1}), 32'h0);
    chk("rst_blank", 32'(blank), 32'h0);
    iRST_N = 1'b1;

    // idle shows default one cycle later
    @(negedge iCLK);
    chk("idle_dig", 32'(dig), 32'h123456);
    chk("idle_owner", 32'(owner), 32'h0);
    chk("idle_acks", 32'({ack0, ack1}), 32'h0);

    // single one-cycle request from requester 0
    data0 = 24'hABCDEF;
    req0  = 1'b1;
    @(negedge iCLK);
    req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge iCLK);
      chk("single_dig", 32'(dig), 32'hABCDEF);
      chk("single_owner", 32'(owner), 32'h1);
      chk("single_ack0", 32'(ack0), (i == 0) ? 32'h1 : 32'h0);
      chk("single_ack1", 32'(ack1), 32'h0);
    end
    @(negedge iCLK);
    chk("single_end_owner", 32'(owner), 32'h0);
    chk("single_end_dig", 32'(dig), 32'h123456);

    // contention: grants alternate every 4 cycles starting with requester 0
    data0 = 24'h000001;
    data1 = 24'h000002;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge iCLK);
      if (((i / 4) % 2) == 0) begin
        chk("cont_owner", 32'(owner), 32'h1);
        chk("cont_dig", 32'(dig), 32'h000001);
        chk("cont_ack0", 32'(ack0), ((i % 4) == 0) ? 32'h1 : 32'h0);
        chk("cont_ack1", 32'(ack1), 32'h0);
      end else begin
        chk("cont_owner", 32'(owner), 32'h2);
        chk("cont_dig", 32'(dig), 32'h000002);
        chk("cont_ack0", 32'(ack0), 32'h0);
        chk("cont_ack1", 32'(ack1), ((i % 4) == 0) ? 32'h1 : 32'h0);
      end
      chk("cont_no_both", 32'(ack0 & ack1), 32'h0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge iCLK);
    chk("cont_end_owner", 32'(owner), 32'h0);

    // reset asserted two cycles into a grant
    data0 = 24'hABCDEF;
    req0  = 1'b1;
    @(negedge iCLK);
    req0 = 1'b0;
    chk("mid_owner", 32'(owner), 32'h1);
    @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    chk("mid_rst_dig", 32'(dig), 32'h0);
    chk("mid_rst_owner", 32'(owner), 32'h0);
    chk("mid_rst_acks", 32'({ack0, ack1}), 32'h0);
    chk("mid_rst_blank", 32'(blank), 32'h0);
    @(negedge iCLK);
    chk("mid_hold_dig", 32'(dig), 32'h0);
    chk("mid_hold_acks", 32'({ack0, ack1}), 32'h0);
    iRST_N = 1'b1;

    // post-reset idle plus blink pattern counted from the first edge after release
    for (int n = 1; n <= 12; n++) begin
      @(negedge iCLK);
      if (n == 1) begin
        chk("post_owner", 32'(owner), 32'h0);
        chk("post_acks", 32'({ack0, ack1}), 32'h0);
        chk("post_dig", 32'(dig), 32'h123456);
      end
`ifdef SEG7_BLINK_EN
      chk("blink", 32'(blank), ((((n - 1) / 3) % 2) == 1) ? 32'h03 : 32'h00);
`else
      chk("blink_off", 32'(blank), 32'h00);
`endif
    end

    // DWELL=1, requester 1 held alone: ack every cycle
    data1 = 24'h00BEEF;
    req1b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge iCLK);
      chk("d1_ack1", 32'(ack1b), 32'h1);
      chk("d1_ack0", 32'(ack0b), 32'h0);
      chk("d1_owner", 32'(owner1), 32'h2);
      chk("d1_dig", 32'(dig1), 32'h00BEEF);
    end
    req1b = 1'b0;
    @(negedge iCLK);
    chk("d1_end_owner", 32'(owner1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_disp_sched.md
SEG7_DISP_SCHED -- requirements
Module: seg7_disp_sched

Interface
REQ-001 SHALL have parameter DWELL, default 50000000, meaning the minimum number of cycles a granted value stays displayed (legal range >= 1).
REQ-002 SHALL have parameter BLINK_DIV, default 12500000, meaning the number of cycles per blink half-period (legal range >= 1).
REQ-003 SHALL have port iCLK  input  1  clock; all state on its rising edge.
REQ-004 SHALL have port iRST_N  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port iDEFAULT  input  24  six hex digits shown when no requester owns the display.
REQ-006 SHALL have port iREQ0  input  1  display request, requester 0.
REQ-007 SHALL have port iDATA0  input  24  six hex digits from requester 0, sampled at grant.
REQ-008 SHALL have port iREQ1  input  1  display request, requester 1.
REQ-009 SHALL have port iDATA1  input  24  six hex digits from requester 1, sampled at grant.
REQ-010 SHALL have port iBLINK_MASK  input  6  per-digit blink select, bit n = digit n (iDIG[4n+3:4n]).
REQ-011 SHALL have port oDIG  output  24  registered digit value for the six seven-segment decoders.
REQ-012 SHALL have port oBLANK  output  6  registered per-digit blank; 1 = digit forced dark downstream.
REQ-013 SHALL have port oACK0  output  1  one-cycle pulse: iDATA0 latched.
REQ-014 SHALL have port oACK1  output  1  one-cycle pulse: iDATA1 latched.
REQ-015 SHALL have port oOWNER  output  2  2'b00 default, 2'b01 requester 0, 2'b10 requester 1.

Function
REQ-016 SHALL implement states IDLE, SHOW0, SHOW1; oOWNER encodes the current state.
REQ-017 SHALL, in IDLE, load oDIG from iDEFAULT every cycle (one-cycle latency).
REQ-018 SHALL, in IDLE with iREQ0 high, latch iDATA0 into oDIG, pulse oACK0, load dwell counter with DWELL-1, enter SHOW0 on the same edge.
REQ-019 SHALL, in IDLE with iREQ0 low and iREQ1 high, do the same for requester 1 (iDATA1, oACK1, SHOW1).
REQ-020 SHALL, in SHOWx with counter > 0, hold oDIG, decrement counter, ignore both requests and iDEFAULT.
REQ-021 SHALL, in SHOW0 with counter == 0: iREQ1 high -> grant 1 (REQ-019 actions, enter SHOW1); else iREQ0 high -> regrant 0 (re-latch, re-ack, reload); else -> IDLE.
REQ-022 SHALL, in SHOW1 with counter == 0: iREQ0 high -> grant 0; else iREQ1 high -> regrant 1; else -> IDLE (alternation on contention).
REQ-023 SHALL never assert oACK0 and oACK1 in the same cycle; each ack is high exactly on the cycle following the latching edge.
REQ-024 SHALL, with DWELL = 1, hold a grant exactly one cycle before re-arbitration.
REQ-025 SHALL size the dwell counter to $clog2(DWELL) bits, minimum 1; no wrap, decrement stops at 0.
REQ-026 SHALL NOT require requests to drop after ack; a held request is served again on its next arbitration turn.

Reset
REQ-027 SHALL, with iRST_N low, asynchronously force: state IDLE, oDIG 24'h000000, oBLANK 6'b000000, oACK0 0, oACK1 0, oOWNER 2'b00, dwell counter 0, blink counter 0, blink phase 0.
REQ-028 SHALL, on reset asserted mid-grant, abandon the grant without an ack; first post-reset edge behaves as IDLE.

Configuration
REQ-029 SHALL, with macro SEG7_BLINK_EN defined, run a free-running blink counter toggling blink phase every BLINK_DIV cycles and drive oBLANK = phase ? iBLINK_MASK : 6'b0, registered.
REQ-030 SHALL, without SEG7_BLINK_EN, drive oBLANK constant 6'b0, ignore iBLINK_MASK, and implement no blink counter; ports unchanged.

Verification
REQ-031 SHALL cover: DWELL=4, iDEFAULT=24'h123456, no requests -> oDIG=24'h123456 one cycle after edge, oOWNER=00, no acks.
REQ-032 SHALL cover: DWELL=4, one-cycle iREQ0 with iDATA0=24'hABCDEF -> oACK0 pulse, oOWNER=01 and oDIG=24'hABCDEF for exactly 4 cycles, then IDLE showing iDEFAULT.
REQ-033 SHALL cover: DWELL=4, iREQ0 and iREQ1 held high, iDATA0=24'h000001, iDATA1=24'h000002 -> grants alternate 0,1,0,1 every 4 cycles, acks alternate, never coincident.
REQ-034 SHALL cover: DWELL=1, iREQ1 held high alone -> oACK1 every cycle, oOWNER=10 continuously.
REQ-035 SHALL cover: iRST_N low 2 cycles into a SHOW0 grant -> all outputs zero immediately, no ack, IDLE after release.
REQ-036 SHALL cover: SEG7_BLINK_EN defined, BLINK_DIV=3, iBLINK_MASK=6'b000011 -> oBLANK alternates 000000/000011 every 3 cycles; undefined -> oBLANK stays 000000.
